// File: rtl/uart_tick_gen.sv
// Oversampling UART timebase: fractional divisor -> sample/mid/bit clock-enable pulses.
// Divisor changes are staged in a shadow register and only take effect on a bit boundary.
module uart_tick_gen #(
  parameter int DIV_W       = 16,
  parameter int FRAC_W      = 4,
  parameter int OVS         = 16,
  parameter int DEFAULT_DIV = 326,
  localparam int IDX_W      = (OVS > 1) ? $clog2(OVS) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_enable,
  input  logic [DIV_W-1:0]  i_div_int,
  input  logic [FRAC_W-1:0] i_div_frac,
  input  logic              i_div_load,
  input  logic              i_resync,
  output logic              o_sample_tick,
  output logic              o_mid_tick,
  output logic              o_bit_tick,
  output logic [IDX_W-1:0]  o_sample_idx,
  output logic              o_div_err
);

  localparam logic [IDX_W-1:0] MID_IDX  = IDX_W'(OVS/2 - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(OVS - 1);
  localparam logic [DIV_W:0]   CNT_ONE  = (DIV_W+1)'(1);
  localparam logic [DIV_W-1:0] DIV_MIN  = DIV_W'(2);

  // One extra counter bit so div = 2^DIV_W-1 plus the fractional carry cannot overflow.
  logic [DIV_W:0]    r_cnt;
  logic [FRAC_W-1:0] r_acc;
  logic              r_ext;
  logic [DIV_W-1:0]  r_div_act, r_div_shd;
  logic [FRAC_W-1:0] r_frac_act, r_frac_shd;
  logic              r_pend;
  logic [IDX_W-1:0]  r_idx;
  logic              r_sample, r_mid, r_bit, r_err;

  logic [DIV_W:0]    w_per_m1;
  logic              w_term;
  logic              w_last;
  logic              w_ld_err;
  logic [DIV_W-1:0]  w_ld_div;
  logic [FRAC_W:0]   w_acc_sum;

  assign w_per_m1  = {1'b0, r_div_act} + {{DIV_W{1'b0}}, r_ext} - CNT_ONE;
  // >= rather than == so an immediate divisor shrink while idle cannot strand the counter.
  assign w_term    = i_enable && (r_cnt >= w_per_m1);
  assign w_last    = w_term && (r_idx == LAST_IDX);
  assign w_ld_err  = (i_div_int < DIV_MIN);
  assign w_ld_div  = w_ld_err ? DIV_MIN : i_div_int;
  assign w_acc_sum = {1'b0, r_acc} + {1'b0, r_frac_act};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt      <= '0;
      r_acc      <= '0;
      r_ext      <= 1'b0;
      r_div_act  <= DIV_W'(DEFAULT_DIV);
      r_div_shd  <= DIV_W'(DEFAULT_DIV);
      r_frac_act <= '0;
      r_frac_shd <= '0;
      r_pend     <= 1'b0;
      r_idx      <= '0;
      r_sample   <= 1'b0;
      r_mid      <= 1'b0;
      r_bit      <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      if (i_div_load) r_err <= w_ld_err;
      if (i_div_load && i_resync) begin
        r_div_act  <= w_ld_div;
        r_frac_act <= i_div_frac;
        r_div_shd  <= w_ld_div;
        r_frac_shd <= i_div_frac;
        r_pend     <= 1'b0;
      end else if (i_div_load) begin
        r_div_shd  <= w_ld_div;
        r_frac_shd <= i_div_frac;
        r_pend     <= 1'b1;
      end else if (r_pend && (i_resync || !i_enable || w_last)) begin
        r_div_act  <= r_div_shd;
        r_frac_act <= r_frac_shd;
        r_pend     <= 1'b0;
      end

      r_sample <= 1'b0;
      r_mid    <= 1'b0;
      r_bit    <= 1'b0;
      if (i_resync) begin
        r_cnt <= '0;
        r_idx <= '0;
        r_acc <= '0;
        r_ext <= 1'b0;
      end else begin
        // Index advances the cycle after the pulse so the output index matches mid/bit.
        if (r_sample) r_idx <= (r_idx == LAST_IDX) ? '0 : r_idx + IDX_W'(1);
        if (w_term) begin
          r_cnt          <= '0;
          r_sample       <= 1'b1;
          r_mid          <= (r_idx == MID_IDX);
          r_bit          <= (r_idx == LAST_IDX);
          {r_ext, r_acc} <= w_acc_sum;
        end else if (i_enable) begin
          r_cnt <= r_cnt + CNT_ONE;
        end
      end
    end
  end

  assign o_sample_tick = r_sample;
  assign o_mid_tick    = r_mid;
  assign o_bit_tick    = r_bit;
  assign o_sample_idx  = r_idx;
  assign o_div_err     = r_err;

endmodule

// File: tb/tb_uart_tick_gen.sv
// Directed bench for uart_tick_gen: rates, fractional spacing, clamp, staged loads, resync, reset.
module tb_uart_tick_gen;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        i_enable = 1'b0;
  logic [15:0] i_div_int = '0;
  logic [3:0]  i_div_frac = '0;
  logic        i_div_load = 1'b0;
  logic        i_resync = 1'b0;
  logic        o_sample_tick, o_mid_tick, o_bit_tick, o_div_err;
  logic [3:0]  o_sample_idx;

  int n_pass = 0;
  int n_total = 0;

  uart_tick_gen dut (
    .clk(clk), .reset(reset), .i_enable(i_enable), .i_div_int(i_div_int),
    .i_div_frac(i_div_frac), .i_div_load(i_div_load), .i_resync(i_resync),
    .o_sample_tick(o_sample_tick), .o_mid_tick(o_mid_tick), .o_bit_tick(o_bit_tick),
    .o_sample_idx(o_sample_idx), .o_div_err(o_div_err)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Cycles until the next sample_tick is seen; -1 when the bound expires.
  task automatic wait_tick(input int max, output int n);
    n = -1;
    for (int i = 1; i <= max; i++) begin
      @(negedge clk);
      if (o_sample_tick) begin n = i; return; end
    end
  endtask

  task automatic load(input logic [15:0] d, input logic [3:0] f);
    i_div_int = d; i_div_frac = f; i_div_load = 1'b1;
    @(negedge clk);
    i_div_load = 1'b0;
  endtask

  task automatic do_reset(input logic en);
    @(negedge clk);
    reset = 1'b1; i_enable = 1'b0; i_div_load = 1'b0; i_resync = 1'b0;
    cyc(2);
    reset = 1'b0; i_enable = en;
  endtask

  task automatic test_reset;
    @(negedge clk);
    reset = 1'b1;
    cyc(1);
    n_total++; if (o_sample_tick !== 1'b0) $display("FAIL reset_tick: got %b want 0", o_sample_tick); else n_pass++;
    n_total++; if ({o_mid_tick, o_bit_tick} !== 2'b00) $display("FAIL reset_mid_bit: got %b want 00", {o_mid_tick, o_bit_tick}); else n_pass++;
    n_total++; if (o_sample_idx !== 4'd0) $display("FAIL reset_idx: got %0d want 0", o_sample_idx); else n_pass++;
    n_total++; if (o_div_err !== 1'b0) $display("FAIL reset_err: got %b want 0", o_div_err); else n_pass++;
  endtask

  task automatic test_default_rate;
    int n, t, t_mid, t_bit, bad;
    do_reset(1'b1);
    wait_tick(400, n);
    n_total++; if (n !== 326) $display("FAIL default_first: got %0d want 326", n); else n_pass++;
    t = n; t_mid = -1; t_bit = -1; bad = 0;
    cyc(1);
    n_total++; if (o_sample_tick !== 1'b0) $display("FAIL tick_width: got %b want 0", o_sample_tick); else n_pass++;
    if (o_mid_tick) t_mid = t;
    for (int k = 2; k <= 16; k++) begin
      wait_tick(400, n);
      if (k == 2) n = n + 1;
      if (n != 326) bad++;
      t = t + n;
      if (o_mid_tick) begin
        t_mid = t;
        n_total++; if (o_sample_idx !== 4'd7) $display("FAIL mid_idx: got %0d want 7", o_sample_idx); else n_pass++;
      end
      if (o_bit_tick) t_bit = t;
    end
    n_total++; if (bad !== 0) $display("FAIL default_gaps: got %0d wrong gaps want 0", bad); else n_pass++;
    n_total++; if (t_mid !== 2608) $display("FAIL default_mid_time: got %0d want 2608", t_mid); else n_pass++;
    n_total++; if (t_bit !== 5216) $display("FAIL default_bit_time: got %0d want 5216", t_bit); else n_pass++;
    n_total++; if (o_sample_idx !== 4'd15) $display("FAIL bit_idx: got %0d want 15", o_sample_idx); else n_pass++;
  endtask

  task automatic test_frac;
    int g [1:17];
    int sum;
    do_reset(1'b0);
    load(16'd3, 4'd8);
    cyc(2);
    i_enable = 1'b1;
    for (int k = 1; k <= 17; k++) wait_tick(20, g[k]);
    n_total++; if (g[1] !== 3 || g[2] !== 3 || g[3] !== 4 || g[4] !== 3 || g[5] !== 4)
      $display("FAIL frac_gaps: got %0d %0d %0d %0d %0d want 3 3 4 3 4", g[1], g[2], g[3], g[4], g[5]);
    else n_pass++;
    sum = 0;
    for (int k = 2; k <= 17; k++) sum += g[k];
    n_total++; if (sum !== 56) $display("FAIL frac_16ticks: got %0d want 56", sum); else n_pass++;
  endtask

  task automatic test_err;
    int n1, n2;
    do_reset(1'b0);
    load(16'd1, 4'd0);
    n_total++; if (o_div_err !== 1'b1) $display("FAIL err_set: got %b want 1", o_div_err); else n_pass++;
    cyc(1);
    i_enable = 1'b1;
    wait_tick(20, n1);
    wait_tick(20, n2);
    n_total++; if (n1 !== 2 || n2 !== 2) $display("FAIL err_clamp_period: got %0d %0d want 2 2", n1, n2); else n_pass++;
    load(16'd5, 4'd0);
    n_total++; if (o_div_err !== 1'b0) $display("FAIL err_clear: got %b want 0", o_div_err); else n_pass++;
  endtask

  task automatic test_div_change;
    int n, bad;
    do_reset(1'b0);
    load(16'd4, 4'd0);
    cyc(2);
    i_enable = 1'b1;
    for (int k = 0; k < 20; k++) begin
      wait_tick(20, n);
      if (o_sample_idx == 4'd3) break;
    end
    load(16'd8, 4'd0);
    bad = 0;
    for (int k = 1; k <= 12; k++) begin
      wait_tick(20, n);
      if (k == 1) n = n + 1;
      if (n != 4) bad++;
    end
    n_total++; if (bad !== 0) $display("FAIL change_old_gaps: got %0d wrong want 0", bad); else n_pass++;
    n_total++; if (o_bit_tick !== 1'b1) $display("FAIL change_bit_tick: got %b want 1", o_bit_tick); else n_pass++;
    wait_tick(20, n);
    n_total++; if (n !== 8) $display("FAIL change_new_gap1: got %0d want 8", n); else n_pass++;
    wait_tick(20, n);
    n_total++; if (n !== 8) $display("FAIL change_new_gap2: got %0d want 8", n); else n_pass++;
  endtask

  task automatic test_resync;
    int n, mid_at;
    do_reset(1'b0);
    load(16'd4, 4'd0);
    cyc(2);
    i_enable = 1'b1;
    for (int k = 0; k < 20; k++) begin
      wait_tick(20, n);
      if (o_sample_idx == 4'd9) break;
    end
    cyc(2);
    i_resync = 1'b1;
    cyc(1);
    i_resync = 1'b0;
    n_total++; if (o_sample_tick !== 1'b0) $display("FAIL resync_no_tick: got %b want 0", o_sample_tick); else n_pass++;
    wait_tick(20, n);
    n_total++; if (n !== 4) $display("FAIL resync_period: got %0d want 4", n); else n_pass++;
    n_total++; if (o_sample_idx !== 4'd0) $display("FAIL resync_idx: got %0d want 0", o_sample_idx); else n_pass++;
    mid_at = -1;
    for (int k = 2; k <= 9; k++) begin
      wait_tick(20, n);
      if (o_mid_tick && mid_at < 0) mid_at = k;
    end
    n_total++; if (mid_at !== 8) $display("FAIL resync_mid: got tick %0d want 8", mid_at); else n_pass++;
    // Resync landing on the terminal count suppresses that tick.
    wait_tick(20, n);
    cyc(3);
    i_resync = 1'b1;
    cyc(1);
    i_resync = 1'b0;
    n_total++; if (o_sample_tick !== 1'b0 || o_sample_idx !== 4'd0)
      $display("FAIL resync_vs_term: got tick %b idx %0d want 0 0", o_sample_tick, o_sample_idx);
    else n_pass++;
    wait_tick(20, n);
    n_total++; if (n !== 4) $display("FAIL resync_term_period: got %0d want 4", n); else n_pass++;
    // Load together with resync takes effect at once.
    i_div_int = 16'd6; i_div_frac = 4'd0; i_div_load = 1'b1; i_resync = 1'b1;
    cyc(1);
    i_div_load = 1'b0; i_resync = 1'b0;
    wait_tick(20, n);
    n_total++; if (n !== 6) $display("FAIL load_resync: got %0d want 6", n); else n_pass++;
  endtask

  task automatic test_async_reset;
    int n;
    for (int k = 0; k < 20; k++) begin
      wait_tick(20, n);
      if (o_mid_tick) break;
    end
    #1 reset = 1'b1;
    #1;
    n_total++; if ({o_sample_tick, o_mid_tick, o_bit_tick} !== 3'b000 || o_sample_idx !== 4'd0)
      $display("FAIL async_reset: got %b idx %0d want 000 idx 0", {o_sample_tick, o_mid_tick, o_bit_tick}, o_sample_idx);
    else n_pass++;
    @(negedge clk);
    reset = 1'b0;
    wait_tick(400, n);
    n_total++; if (n !== 326 || o_sample_idx !== 4'd0)
      $display("FAIL post_reset_rate: got %0d idx %0d want 326 idx 0", n, o_sample_idx);
    else n_pass++;
  endtask

  initial begin
    test_reset;
    test_default_rate;
    test_frac;
    test_err;
    test_div_change;
    test_resync;
    test_async_reset;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
